// File: rtl/disp7_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : disp7_pkg
//  Description : Shared definitions for the multiplexed 7-segment display
//                path: the .gfedcba hex decode table, the scanner state
//                type and a leading-zero mask helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package disp7_pkg;

    // Logical segment patterns {g,f,e,d,c,b,a}; entry 0 is the rightmost.
    localparam logic [15:0][6:0] SEG7_LUT = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_e;

    // Bit i set means digit i is a leading zero: nibbles i..n-1 are all
    // zero. Digit 0 is never marked. Handles up to 8 digits.
    function automatic logic [7:0] lz_mask(input logic [31:0] v, input int n);
        logic [7:0] m;
        logic       zero_run;
        m        = '0;
        zero_run = 1'b1;
        for (int i = 7; i >= 1; i--) begin
            if (i < n) begin
                zero_run = zero_run & (v[4*i +: 4] == 4'h0);
                m[i]     = zero_run;
            end
        end
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_hex_dec.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_hex_dec
//  Description : Combinational hex nibble to logical 7-segment decoder.
//                Ports: nib_i [3:0] hex digit; seg_o [6:0] {g..a}, 1 = lit.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_hex_dec
    import disp7_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG7_LUT[nib_i];

endmodule
`default_nettype wire

// File: rtl/disp7_scan.sv
`default_nettype none
// ============================================================================
//  Module      : disp7_scan
//  Description : Time-multiplexed hex display scanner with per-digit dwell,
//                inter-digit blanking, frame-boundary value update and
//                optional leading-zero blanking.
//  Ports       : clk, rst        clock / synchronous active-high reset
//                val_i, dp_i     value nibbles and decimal points
//                load_i          capture val_i/dp_i into the pending register
//                blank_lz_i      blank leading zero digits
//                en_i            0 = dark, scanner parked
//                seg_o           {dp,g,f,e,d,c,b,a} (polarity per SEG_INV)
//                an_o            one-hot digit select (polarity per AN_ACT_LOW)
//                frame_o         pulse on first SHOW cycle of digit 0
//                pend_o          pending value not yet applied
//  Revision    : 1.0 - initial release
// ============================================================================
module disp7_scan
    import disp7_pkg::*;
#(
    parameter int N_DIG      = 4,
    parameter int DWELL      = 50000,
    parameter int BLANK      = 500,
    parameter int SEG_INV    = 0,
    parameter int AN_ACT_LOW = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [4*N_DIG-1:0] val_i,
    input  logic [N_DIG-1:0]   dp_i,
    input  logic               load_i,
    input  logic               blank_lz_i,
    input  logic               en_i,
    output logic [7:0]         seg_o,
    output logic [N_DIG-1:0]   an_o,
    output logic               frame_o,
    output logic               pend_o
);

    localparam int DW   = $clog2(N_DIG);
    localparam int CMAX = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    localparam logic [N_DIG-1:0] AN_OFF  = (AN_ACT_LOW != 0) ? {N_DIG{1'b1}} : {N_DIG{1'b0}};
    localparam logic [7:0]       SEG_OFF = (SEG_INV != 0) ? 8'hFF : 8'h00;

    scan_state_e        state_q, state_d;
    logic [DW-1:0]      digit_q, digit_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               restart_q, restart_d;   // next SHOW enters digit 0
    logic               pend_q, pend_d;
    logic [4*N_DIG-1:0] pval_q, pval_d;
    logic [N_DIG-1:0]   pdp_q, pdp_d;
    logic [4*N_DIG-1:0] dval_q, dval_d;
    logic [N_DIG-1:0]   ddp_q, ddp_d;
    logic [7:0]         seg_q, seg_d;
    logic [N_DIG-1:0]   an_q, an_d;
    logic               frame_q, frame_d;

    logic               enter_show;
    logic [3:0]         nib;
    logic [6:0]         dec;
    logic [7:0]         lz;

    // Scanner sequencing and the pending/display register update.
    always_comb begin
        state_d    = state_q;
        digit_d    = digit_q;
        cnt_d      = cnt_q;
        restart_d  = restart_q;
        pend_d     = pend_q;
        pval_d     = pval_q;
        pdp_d      = pdp_q;
        dval_d     = dval_q;
        ddp_d      = ddp_q;
        enter_show = 1'b0;

        if (!en_i) begin
            state_d   = ST_BLANK;
            digit_d   = '0;
            cnt_d     = '0;
            restart_d = 1'b1;
        end else begin
            case (state_q)
                ST_BLANK: begin
                    if (cnt_q == CW'(BLANK - 1)) begin
                        state_d    = ST_SHOW;
                        cnt_d      = '0;
                        restart_d  = 1'b0;
                        enter_show = 1'b1;
                        if (restart_q || digit_q == DW'(N_DIG - 1))
                            digit_d = '0;
                        else
                            digit_d = digit_q + 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_SHOW: begin
                    if (cnt_q == CW'(DWELL - 1)) begin
                        state_d = ST_BLANK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                end
            endcase
        end

        if (load_i) begin
            pval_d = val_i;
            pdp_d  = dp_i;
            pend_d = 1'b1;
        end

        // Frame-boundary apply; a load in the same cycle bypasses the
        // pending register so the newest value is shown immediately.
        if (enter_show && digit_d == '0 && (pend_q || load_i)) begin
            dval_d = load_i ? val_i : pval_q;
            ddp_d  = load_i ? dp_i  : pdp_q;
            pend_d = 1'b0;
        end
    end

    assign nib = dval_d[4*digit_d +: 4];

    seg7_hex_dec u_dec (
        .nib_i (nib),
        .seg_o (dec)
    );

    // Outputs are computed from next-state values so seg/an/frame update on
    // the same edge as the state register.
    always_comb begin
        logic [7:0]       seg_log;
        logic [N_DIG-1:0] an_log;
        seg_log = 8'h00;
        an_log  = '0;
        lz      = blank_lz_i ? lz_mask(32'(dval_d), N_DIG) : 8'h00;
        if (state_d == ST_SHOW) begin
            seg_log          = {ddp_d[digit_d], lz[digit_d] ? 7'h00 : dec};
            an_log[digit_d]  = 1'b1;
        end
        seg_d   = (SEG_INV != 0) ? ~seg_log : seg_log;
        an_d    = (AN_ACT_LOW != 0) ? ~an_log : an_log;
        frame_d = enter_show && (digit_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_BLANK;
            digit_q   <= '0;
            cnt_q     <= '0;
            restart_q <= 1'b1;
            pend_q    <= 1'b0;
            pval_q    <= '0;
            pdp_q     <= '0;
            dval_q    <= '0;
            ddp_q     <= '0;
            seg_q     <= SEG_OFF;
            an_q      <= AN_OFF;
            frame_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            digit_q   <= digit_d;
            cnt_q     <= cnt_d;
            restart_q <= restart_d;
            pend_q    <= pend_d;
            pval_q    <= pval_d;
            pdp_q     <= pdp_d;
            dval_q    <= dval_d;
            ddp_q     <= ddp_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
            frame_q   <= frame_d;
        end
    end

    assign seg_o   = seg_q;
    assign an_o    = an_q;
    assign frame_o = frame_q;
    assign pend_o  = pend_q;

endmodule
`default_nettype wire
